// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encodings and ACK/NAK defaults.
package uart_program_loader_pkg;

  localparam logic [2:0] ST_HDR  = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_CSUM = 3'd2;
  localparam logic [2:0] ST_ACK  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;
  localparam logic [7:0] NAK_BYTE_DEF = 8'h55;

endpackage

// File: rtl/uart_program_loader_byte_packer.sv
// Big-endian 8->32 packer: word_valid_o fires with the 4th byte, word_o is combinational.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  // Next byte count and shift contents
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (in_valid) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], in_data};
    end else begin
      cnt_d   = cnt_q;
    end
  end

  // Packer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign word_o       = {shift_q, in_data};
  assign word_valid_o = in_valid && (cnt_q == 2'd3);

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: length-prefixed UART program -> word-addressed IMEM, then ACK and release the core.
// Optional trailing checksum word enabled with `define LOADER_CHECKSUM_EN.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int         ADDR_W   = 15,
  parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF,
  parameter logic [7:0] NAK_BYTE = NAK_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_err
);

  localparam logic [32:0] CAP = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d, wcnt_q, wcnt_d;
  logic              sent_q, sent_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              load_err_q, load_err_d;
  logic              pk_in_valid, pk_word_valid, rx_bad;
  logic [31:0]       pk_word;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  // Only good bytes in receiving states reach the packer; a framing error never gets packed
  assign rx_bad      = rx_valid && rx_ferr;
  assign pk_in_valid = rx_valid && !rx_ferr &&
                       ((state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CSUM));

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (pk_in_valid),
    .in_data      (rx_data),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  // FSM next state and output pulses
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    wcnt_d     = wcnt_q;
    sent_d     = sent_q;
    tx_start_d = 1'b0;
    tx_data_d  = 8'd0;
    we_d       = 1'b0;
    addr_d     = '0;
    wdata_d    = 32'd0;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      ST_HDR: begin
        if (rx_bad) begin
          state_d = ST_ERR;
        end else if (pk_word_valid) begin
          if (pk_word == 32'd0) begin
            state_d = ST_ACK;
          end else if ({1'b0, pk_word} > CAP) begin
            state_d = ST_ERR;
          end else begin
            n_d     = pk_word[ADDR_W:0];
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_LOAD: begin
        if (rx_bad) begin
          state_d = ST_ERR;
        end else if (pk_word_valid) begin
          we_d    = 1'b1;
          addr_d  = wcnt_q[ADDR_W-1:0];
          wdata_d = pk_word;
          wcnt_d  = wcnt_q + ONE;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + pk_word;
          state_d = (wcnt_d == n_q) ? ST_CSUM : ST_LOAD;
`else
          state_d = (wcnt_d == n_q) ? ST_ACK : ST_LOAD;
`endif
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_bad) begin
          state_d = ST_ERR;
        end else if (pk_word_valid) begin
          state_d = (pk_word == sum_q) ? ST_ACK : ST_ERR;
        end else begin
          state_d = ST_CSUM;
        end
      end
`endif
      // Pulse lands in the last ACK cycle; DONE follows the cycle after
      ST_ACK: begin
        if (sent_q) begin
          state_d = ST_DONE;
        end else if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = ACK_BYTE;
          sent_d     = 1'b1;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR: begin
        if (!sent_q && !tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = NAK_BYTE;
          sent_d     = 1'b1;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_ERR;
    endcase
    cpu_run_d  = (state_d == ST_DONE);
    load_err_d = (state_d == ST_ERR);
  end

  // Loader state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HDR;
      n_q        <= '0;
      wcnt_q     <= '0;
      sent_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      cpu_run_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      wcnt_q     <= wcnt_d;
      sent_q     <= sent_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_run_q  <= cpu_run_d;
      load_err_q <= load_err_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running checksum of data words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= 32'd0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_run    = cpu_run_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Table-driven bench for uart_program_loader with IMEM-write and TX scoreboards.
module tb_uart_program_loader;

  localparam int AW = 4;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ferr = 1'b0;
  logic          tx_busy = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_run;
  logic          load_err;

  int checks = 0;
  int failures = 0;
  int tx_cnt = 0;
  logic busy_at_edge = 1'b0;
  logic [AW+31:0] wr_q[$];
  logic [7:0]     tx_q[$];
  logic [31:0]    wbuf[0:31];

  uart_program_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      busy_at_edge = tx_busy;
    end
  end

  // Scoreboard monitor, sampling on the falling edge
  initial begin
    logic [AW+31:0] ew;
    logic [7:0] et;
    forever begin
      @(negedge clk);
      if (imem_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_we", {imem_addr, imem_wdata}, 64'd0);
        end else begin
          ew = wr_q.pop_front();
          check("imem_write", {imem_addr, imem_wdata}, ew);
        end
      end
      if (tx_start) begin
        tx_cnt++;
        check("tx_while_busy", busy_at_edge, 1'b0);
        if (tx_q.size() == 0) begin
          check("unexpected_tx", tx_data, 64'h1FF);
        end else begin
          et = tx_q.pop_front();
          check("tx_byte", tx_data, et);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic f);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1; rx_ferr = f;
    @(negedge clk);
    rx_valid = 1'b0; rx_ferr = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0; rx_ferr = 1'b0; tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {tx_start, tx_data, imem_we, imem_addr, imem_wdata, cpu_run, load_err}, 64'd0);
    wr_q.delete(); tx_q.delete();
    rst = 1'b0;
    tx_cnt = 0;
  endtask

  // Drive header, data (optionally with a framing error) and checksum; expect ACK or NAK
  task automatic do_load(input logic [31:0] n, input int ferr_idx, input bit bad, input int busy, input bit exp_ok);
    logic [31:0] sum;
    logic [AW-1:0] a;
    bit aborted, sends, ok;
    sum = 32'd0; aborted = 1'b0;
    sends = (n != 32'd0) && (n <= (32'd1 << AW));
    ok = exp_ok && !(CSUM && bad);
    tx_cnt = 0;
    if (busy > 0) tx_busy = 1'b1;
    send_word(n);
    if (sends) begin
      for (int i = 0; i < int'(n); i++) begin
        for (int b = 0; b < 4; b++) begin
          if (!aborted) begin
            if (i * 4 + b == ferr_idx) begin
              send_byte(wbuf[i][31-8*b -: 8], 1'b1);
              aborted = 1'b1;
            end else if (b == 3) begin
              a = i[AW-1:0];
              wr_q.push_back({a, wbuf[i]});
              send_byte(wbuf[i][7:0], 1'b0);
              check("we_latency", imem_we, 1'b1);
            end else begin
              send_byte(wbuf[i][31-8*b -: 8], 1'b0);
            end
          end
        end
        sum = sum + wbuf[i];
      end
      if (CSUM && !aborted) send_word(bad ? sum + 32'd1 : sum);
    end
    tx_q.push_back(ok ? 8'hAA : 8'h55);
    if (busy > 0) begin
      repeat (busy) @(negedge clk);
      check("tx_held_busy", tx_cnt, 0);
      tx_busy = 1'b0;
    end
    for (int k = 0; k < 100 && tx_q.size() != 0; k++) @(negedge clk);
    if (tx_q.size() != 0) begin
      check("tx_timeout", tx_q.size(), 0);
      tx_q.delete();
    end
    repeat (4) @(negedge clk);
    check("cpu_run", cpu_run, ok);
    check("load_err", load_err, !ok);
    check("tx_count", tx_cnt, 1);
    check("writes_pending", wr_q.size(), 0);
    wr_q.delete();
  endtask

  typedef struct {
    logic [31:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    int          ferr_idx;
    bit          bad;
    int          busy;
    bit          exp_ok;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'd2,          32'h11223344, 32'hA5A5A5A5, -1, 1'b0, 0, 1'b1};
    vecs[1] = '{32'd0,          32'h0,        32'h0,        -1, 1'b0, 0, 1'b1};
    vecs[2] = '{32'd17,         32'h0,        32'h0,        -1, 1'b0, 0, 1'b0};
    vecs[3] = '{32'd1,          32'hDEADBEEF, 32'h0,         2, 1'b0, 0, 1'b0};
    vecs[4] = '{32'd1,          32'h01020304, 32'h0,        -1, 1'b0, 6, 1'b1};
    vecs[5] = '{32'd16,         32'h0F0E0D0C, 32'h80000000, -1, 1'b0, 0, 1'b1};
    vecs[6] = '{32'd2,          32'h00000001, 32'hFFFFFFFF, -1, 1'b0, 0, 1'b1};
    vecs[7] = '{32'd2,          32'h00000001, 32'hFFFFFFFF, -1, 1'b1, 0, 1'b1};
    vecs[8] = '{32'hFFFFFFFF,   32'h0,        32'h0,        -1, 1'b0, 3, 1'b0};

    for (int v = 0; v < 9; v++) begin
      wbuf[0] = vecs[v].w0;
      wbuf[1] = vecs[v].w1;
      for (int i = 2; i < 32; i++) wbuf[i] = 32'h5A000000 ^ (32'(i) * 32'h00010203);
      do_reset();
      do_load(vecs[v].n, vecs[v].ferr_idx, vecs[v].bad, vecs[v].busy, vecs[v].exp_ok);
    end

    // Reset after 5 data bytes aborts the load
    do_reset();
    wbuf[0] = 32'h01234567;
    send_word(32'd2);
    for (int b = 0; b < 4; b++) begin
      if (b == 3) wr_q.push_back({4'd0, wbuf[0]});
      send_byte(wbuf[0][31-8*b -: 8], 1'b0);
    end
    send_byte(8'h99, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("mid_reset_outputs", {tx_start, tx_data, imem_we, imem_addr, imem_wdata, cpu_run, load_err}, 64'd0);
    check("mid_reset_writes", wr_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    wr_q.delete(); tx_q.delete();
    wbuf[0] = 32'hCAFEF00D;
    do_load(32'd1, -1, 1'b0, 0, 1'b1);

    // DONE ignores further traffic; reset drops cpu_run at once
    tx_cnt = 0;
    send_word(32'd1);
    send_word(32'h12345678);
    repeat (4) @(negedge clk);
    check("done_ignores_rx_run", cpu_run, 1'b1);
    check("done_ignores_rx_tx", tx_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("reset_from_done", cpu_run, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
